// File: rtl/rob_pkg.sv
// Shared types for the read-reorder path: UID / original-ID types, order FIFO entry,
// and the release-sequencer FSM state encoding.
package rob_pkg;
  localparam int ID_WIDTH      = 4;
  localparam int ORIG_ID_WIDTH = 4;

  typedef logic [ID_WIDTH-1:0]      uid_t;
  typedef logic [ORIG_ID_WIDTH-1:0] orig_id_t;

  typedef struct packed {
    uid_t     uid;
    orig_id_t orig_id;
  } order_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    RELEASE = 2'd2
  } rrs_state_e;
endpackage

// File: rtl/r_if.sv
// AXI-style R channel bundle: sender drives payload/valid, receiver drives ready.
interface r_if #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 64,
  parameter int RESP_W = 2
);
  logic              valid;
  logic              ready;
  logic [ID_W-1:0]   id;
  logic [DATA_W-1:0] data;
  logic [RESP_W-1:0] resp;
  logic              last;

  modport sender   (output valid, id, data, resp, last, input ready);
  modport receiver (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/rrs_order_fifo.sv
// Synchronous FIFO of order entries keeping AR issue order; push is dropped when full,
// pop is dropped when empty.
module rrs_order_fifo
  import rob_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  order_entry_t               wdata_i,
  input  logic                       pop_i,
  output order_entry_t               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  order_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/r_release_sequencer.sv
// Drains per-UID read bursts from the response memory in AR issue order, restores the
// master's ARID and returns each UID after its last beat. Optional watchdog: RRS_TIMEOUT_EN.
module r_release_sequencer
  import rob_pkg::*;
#(
  parameter int NUM_UIDS      = 16,
  parameter int MAX_BEATS     = 8,
  parameter int ID_WIDTH      = 4,
  parameter int ORIG_ID_WIDTH = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int RESP_WIDTH    = 2
`ifdef RRS_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [ID_WIDTH-1:0]      alloc_uid,
  input  logic [ORIG_ID_WIDTH-1:0] alloc_orig_id,
  output logic                     free_req,
  output logic [ID_WIDTH-1:0]      uid_to_free,
  input  logic                     free_ack,
  r_if.receiver                    rm_in,
  r_if.sender                      r_out,
  output logic                     uid_release_valid,
  output logic [ID_WIDTH-1:0]      uid_release,
  output logic                     proto_err
`ifdef RRS_TIMEOUT_EN
  , output logic                   timeout_err
`endif
);
  localparam int BC_W  = $clog2(MAX_BEATS+1);
  localparam int CNT_W = $clog2(NUM_UIDS+1);

  rrs_state_e       state_q, state_d;
  logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic             proto_err_q, proto_err_d;
  order_entry_t     head, push_entry;
  logic             fifo_full, fifo_empty, fifo_pop, push;
  logic [CNT_W-1:0] fifo_count;
  logic             hs, force_last, out_last, id_err, len_err;

  assign push       = alloc_valid & alloc_ready;
  assign push_entry = '{uid: uid_t'(alloc_uid), orig_id: orig_id_t'(alloc_orig_id)};

  rrs_order_fifo #(.DEPTH(NUM_UIDS)) u_order_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Registered count only: a pop in the same cycle does not open a slot for a push.
  assign alloc_ready = ~fifo_full;

  assign hs         = (state_q == STREAM) & rm_in.valid & free_ack & r_out.ready;
  assign force_last = (beat_cnt_q == BC_W'(MAX_BEATS-1));
  assign out_last   = rm_in.last | force_last;
  assign id_err     = (state_q == STREAM) & rm_in.valid & (rm_in.id != ID_WIDTH'(head.uid));
  assign len_err    = hs & force_last & ~rm_in.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q | id_err | len_err;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = STREAM;
      STREAM: begin
        if (hs) begin
          if (out_last) begin
            state_d    = RELEASE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      // A push landing alongside the pop still counts as a remaining entry.
      RELEASE: state_d = ((fifo_count > CNT_W'(1)) || push) ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    free_req          = 1'b0;
    uid_to_free       = '0;
    rm_in.ready       = 1'b0;
    r_out.valid       = 1'b0;
    r_out.id          = '0;
    r_out.data        = '0;
    r_out.resp        = '0;
    r_out.last        = 1'b0;
    uid_release_valid = 1'b0;
    uid_release       = '0;
    fifo_pop          = 1'b0;
    case (state_q)
      STREAM: begin
        free_req    = 1'b1;
        uid_to_free = ID_WIDTH'(head.uid);
        rm_in.ready = r_out.ready;
        r_out.valid = rm_in.valid & free_ack;
        r_out.id    = ORIG_ID_WIDTH'(head.orig_id);
        r_out.data  = DATA_WIDTH'(rm_in.data);
        r_out.resp  = RESP_WIDTH'(rm_in.resp);
        r_out.last  = out_last;
      end
      RELEASE: begin
        uid_release_valid = 1'b1;
        uid_release       = ID_WIDTH'(head.uid);
        fifo_pop          = 1'b1;
      end
      default: ;
    endcase
  end

  assign proto_err = proto_err_q;

`ifdef RRS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_err_q;

  always_comb begin
    wd_d = wd_q;
    if (state_q != STREAM || hs)               wd_d = '0;
    else if (wd_q != WD_W'(TIMEOUT_CYCLES))    wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      to_err_q <= to_err_q | (wd_d == WD_W'(TIMEOUT_CYCLES));
    end
  end

  assign timeout_err = to_err_q;
`endif
endmodule
